octa16_seq: RTL and testbench
=============================

Name: octa16_seq

Overview:
- Multi-cycle instruction sequencer for the Octa16 16-bit core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the ALU, register-file, PC and memory control strobes.
- Owns the memory handshake (req/ack) and a wait-timeout fault.
- Sits between the instruction register / flag outputs and the datapath; drives alu_ctrl and alu_flag directly.

Parameters:
- WAIT_MAX, 15: max consecutive un-acked cycles in FETCH or MEM before fault (range 1..255).
- CNT_W, 8: width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  leave IDLE and start sequencing.
- func  in  4  opcode from the instruction register; valid from DECODE onward.
- zero_fl  in  1  ALU zero flag, combinational, valid in EXEC.
- lt_fl  in  1  ALU signed less-than flag, valid in EXEC.
- mem_ack  in  1  memory completes the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (SB), 0 = read.
- addr_sel  out  1  0 = PC drives address, 1 = ALU result.
- ir_load  out  1  load instruction register.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  PC <= branch/jump target.
- alu_ctrl  out  3  ALU operation select.
- alu_flag  out  1  ALU variant select.
- rf_we  out  1  register-file write enable.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- fault  out  1  sticky timeout fault.
- state_dbg  out  3  current state encoding.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Outputs are decoded from state plus func; pc_load in EXEC also depends on the flags.
- Reset: state IDLE, wait counter 0, fault 0, every output 0.
- Async reset mid-operation aborts immediately: mem_req drops with reset, no strobe pulses.
- IDLE: all outputs 0; when run=1 at a rising edge, go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - When mem_ack=1 at an edge: ir_load=1 and pc_inc=1 for that cycle, then go to DECODE.
- DECODE: one cycle, no strobes; go to EXEC.
- EXEC (one cycle), alu_ctrl/alu_flag by func:
  - NAND 0000: 000/0.
  - NOR 1000: 000/1.
  - ADD 0011: 011/0.
  - SUB 1011: 011/1.
  - SRL 0100: 100/0.
  - SLL 1100: 100/1.
  - MOV 1111: 111/0 (pass rs2).
  - These seven ops go to WB.
  - BEQ x101: 011/1; pc_load = zero_fl; go to FETCH.
  - BLT x001: 011/1; pc_load = lt_fl; go to FETCH.
  - JMP 0111: pc_load=1, alu 000/0; go to FETCH.
  - LB x010 / SB x110: 011/0 (address add); go to MEM.
- MEM:
  - mem_req=1, addr_sel=1, alu_ctrl held at 011/0, mem_we=1 for SB.
  - On mem_ack: LB goes to WB; SB goes to FETCH.
- WB:
  - rf_we=1 for exactly one cycle.
  - wb_sel=1 for LB, else 0; LB holds 011/0, ALU ops hold their EXEC alu_ctrl/alu_flag.
  - Go to FETCH.
- Latency with zero-wait ack:
  - ALU ops and MOV: 4 cycles.
  - LB: 5 cycles.
  - SB: 4 cycles.
  - Branch/JMP: 3 cycles.
- run is sampled only in IDLE. Once started, the sequencer free-runs until reset or FAULT.
- Wait counter:
  - Clears on entry to FETCH/MEM and on every ack.
  - Increments each FETCH/MEM cycle without ack.
  - On the edge where it equals WAIT_MAX with no ack: go to FAULT.
  - mem_ack on that same edge wins; no fault.
- FAULT: mem_req=0, all strobes 0, fault=1; exits only on reset.
- mem_ack outside FETCH/MEM is ignored.
- func is don't-care in IDLE and FETCH.

Optional Feature:
- Macro OCTA16_SEQ_PERF_EN.
- When defined: adds output retired[15:0], reset 0.
  - Increments by 1 on each instruction completion: exit from WB, branch/JMP EXEC exit, SB MEM exit.
  - Wraps 0xFFFF to 0x0000.
  - Frozen in FAULT.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, run=1, ack same cycle, func=0011 -> FETCH(ir_load, pc_inc) / DECODE / EXEC alu 011/0 / WB rf_we=1 wb_sel=0; next FETCH at cycle 5.
- func=0101, zero_fl=1, then zero_fl=0 -> pc_load=1 in EXEC for the first, 0 for the second; both return to FETCH with no rf_we.
- func=0010 with mem_ack delayed 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles; WB asserts rf_we=1 with wb_sel=1.
- func=0110 -> MEM asserts mem_we=1, mem_req=1; on ack goes to FETCH with rf_we never asserted.
- mem_ack held 0 in FETCH, WAIT_MAX=15 -> FAULT after 16 FETCH cycles, fault=1, mem_req=0. Variant: ack on the 16th cycle -> DECODE, no fault.
- Assert rst_n=0 mid-MEM -> mem_req drops asynchronously, state_dbg=0. With PERF_EN, retired=0; after 3 ADDs, retired=3.

Source files
------------

// File: rtl/octa16_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the Octa16 core, with memory wait timeout.
// Define OCTA16_SEQ_PERF_EN to add the 16-bit retired-instruction counter output.
module octa16_seq #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] func,
   input  logic       zero_fl,
   input  logic       lt_fl,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic [2:0] alu_ctrl,
   output logic       alu_flag,
   output logic       rf_we,
   output logic       wb_sel,
   output logic       fault,
   output logic [2:0] state_dbg
`ifdef OCTA16_SEQ_PERF_EN
   ,
   output logic [15:0] retired
`endif
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StFault  = 3'd7
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic is_beq, is_blt, is_jmp, is_lb, is_sb, is_mov, is_br, is_mem;
   logic waiting, wait_hit;
   logic [2:0] exec_ctrl;
   logic       exec_flag;

   assign is_beq = (func[2:0] == 3'b101);
   assign is_blt = (func[2:0] == 3'b001);
   assign is_jmp = (func == 4'b0111);
   assign is_lb  = (func[2:0] == 3'b010);
   assign is_sb  = (func[2:0] == 3'b110);
   assign is_mov = (func == 4'b1111);
   assign is_br  = is_beq | is_blt | is_jmp;
   assign is_mem = is_lb | is_sb;

   assign waiting  = (state_q == StFetch) || (state_q == StMem);
   // An ack on the timeout edge wins over the fault.
   assign wait_hit = !mem_ack && (cnt_q == CNT_W'(WAIT_MAX));

   always_comb begin
      exec_ctrl = func[2:0];
      exec_flag = func[3];
      if (is_jmp) begin
         exec_ctrl = 3'b000;
         exec_flag = 1'b0;
      end else if (is_beq || is_blt) begin
         exec_ctrl = 3'b011;
         exec_flag = 1'b1;
      end else if (is_mem) begin
         exec_ctrl = 3'b011;
         exec_flag = 1'b0;
      end else if (is_mov) begin
         exec_ctrl = 3'b111;
         exec_flag = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (waiting && !mem_ack && !wait_hit) ? cnt_q + CNT_W'(1) : '0;
      unique case (state_q)
         StIdle:   if (run) state_d = StFetch;
         StFetch: begin
            if (mem_ack)       state_d = StDecode;
            else if (wait_hit) state_d = StFault;
         end
         StDecode: state_d = StExec;
         StExec: begin
            if (is_br)       state_d = StFetch;
            else if (is_mem) state_d = StMem;
            else             state_d = StWb;
         end
         StMem: begin
            if (mem_ack)       state_d = is_sb ? StFetch : StWb;
            else if (wait_hit) state_d = StFault;
         end
         StWb:     state_d = StFetch;
         StFault:  state_d = StFault;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      alu_ctrl  = 3'b000;
      alu_flag  = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 1'b0;
      fault     = 1'b0;
      state_dbg = state_q;
      unique case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            ir_load = mem_ack;
            pc_inc  = mem_ack;
         end
         StExec: begin
            alu_ctrl = exec_ctrl;
            alu_flag = exec_flag;
            pc_load  = is_jmp | (is_beq & zero_fl) | (is_blt & lt_fl);
         end
         StMem: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_sb;
            alu_ctrl = 3'b011;
         end
         StWb: begin
            rf_we    = 1'b1;
            wb_sel   = is_lb;
            alu_ctrl = exec_ctrl;
            alu_flag = exec_flag;
         end
         StFault: fault = 1'b1;
         default: ;
      endcase
   end

`ifdef OCTA16_SEQ_PERF_EN
   logic retire;
   assign retire = (state_q == StWb) || ((state_q == StExec) && is_br) ||
                   ((state_q == StMem) && mem_ack && is_sb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired <= 16'h0000;
      else if (retire) retired <= retired + 16'h0001;
   end
`endif

endmodule

// File: tb/tb_octa16_seq.sv
// Scoreboard bench for octa16_seq: directed instruction sequences push expected per-cycle
// output vectors; a negedge monitor pops and compares them.
module tb_octa16_seq;

   logic       clk = 1'b0;
   logic       rst_n, run, zero_fl, lt_fl, mem_ack;
   logic [3:0] func;
   logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_flag, rf_we, wb_sel, fault;
   logic [2:0] alu_ctrl, state_dbg;
`ifdef OCTA16_SEQ_PERF_EN
   logic [15:0] retired;
`endif

   octa16_seq #(.WAIT_MAX(15), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .func(func), .zero_fl(zero_fl), .lt_fl(lt_fl),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .alu_ctrl(alu_ctrl),
      .alu_flag(alu_flag), .rf_we(rf_we), .wb_sel(wb_sel), .fault(fault), .state_dbg(state_dbg)
`ifdef OCTA16_SEQ_PERF_EN
      , .retired(retired)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] vec;
      logic [15:0] ret;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_ret = 16'd0;
   logic [15:0] act;

   localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5,
                          SX = 3'd7;

   // {state, req, we, addr_sel, ir_load, pc_inc, pc_load, alu_ctrl, alu_flag, rf_we, wb_sel, fault}
   function automatic logic [15:0] ev(input logic [2:0] st, input logic req, input logic we,
                                      input logic asel, input logic irl, input logic pci,
                                      input logic pcl, input logic [2:0] ctl, input logic fl,
                                      input logic rfw, input logic wbs, input logic flt);
      return {st, req, we, asel, irl, pci, pcl, ctl, fl, rfw, wbs, flt};
   endfunction

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         act = {state_dbg, mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_ctrl,
                alu_flag, rf_we, wb_sel, fault};
         tests++;
         if (act !== mon_e.vec) begin
            fails++;
            $display("FAIL %s: outputs got %h expected %h", mon_e.name, act, mon_e.vec);
         end
`ifdef OCTA16_SEQ_PERF_EN
         tests++;
         if (retired !== mon_e.ret) begin
            fails++;
            $display("FAIL %s retired: got %0d expected %0d", mon_e.name, retired, mon_e.ret);
         end
`endif
      end
   end

   task automatic step(input string nm, input logic r, input logic [3:0] f, input logic z,
                       input logic l, input logic a, input logic [15:0] v);
      exp_t e;
      @(posedge clk);
      #1;
      run = r; func = f; zero_fl = z; lt_fl = l; mem_ack = a;
      e.vec = v; e.ret = exp_ret; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic fetch(input string nm, input int delay, input logic [3:0] f);
      for (int i = 0; i < delay; i++)
         step({nm, " fetch wait"}, 1'b0, f, 1'b0, 1'b0, 1'b0, ev(SF,1,0,0,0,0,0,3'd0,0,0,0,0));
      step({nm, " fetch ack"}, 1'b0, f, 1'b0, 1'b0, 1'b1, ev(SF,1,0,0,1,1,0,3'd0,0,0,0,0));
      // ack during DECODE must be ignored
      step({nm, " decode"}, 1'b0, f, 1'b0, 1'b0, 1'b1, ev(SD,0,0,0,0,0,0,3'd0,0,0,0,0));
   endtask

   task automatic alu_instr(input string nm, input int delay, input logic [3:0] f,
                            input logic [2:0] ctl, input logic fl);
      fetch(nm, delay, f);
      step({nm, " exec"}, 1'b0, f, 1'b1, 1'b1, 1'b0, ev(SE,0,0,0,0,0,0,ctl,fl,0,0,0));
      step({nm, " wb"}, 1'b0, f, 1'b0, 1'b0, 1'b0, ev(SW,0,0,0,0,0,0,ctl,fl,1,0,0));
      exp_ret++;
   endtask

   task automatic branch(input string nm, input logic [3:0] f, input logic z, input logic l,
                         input logic pcl, input logic [2:0] ctl, input logic fl);
      fetch(nm, 0, f);
      step({nm, " exec"}, 1'b0, f, z, l, 1'b0, ev(SE,0,0,0,0,0,pcl,ctl,fl,0,0,0));
      exp_ret++;
   endtask

   task automatic mem_instr(input string nm, input logic [3:0] f, input int delay,
                            input logic st);
      fetch(nm, 0, f);
      step({nm, " exec"}, 1'b0, f, 1'b0, 1'b0, 1'b0, ev(SE,0,0,0,0,0,0,3'd3,0,0,0,0));
      for (int i = 0; i < delay; i++)
         step({nm, " mem wait"}, 1'b0, f, 1'b0, 1'b0, 1'b0, ev(SM,1,st,1,0,0,0,3'd3,0,0,0,0));
      step({nm, " mem ack"}, 1'b0, f, 1'b0, 1'b0, 1'b1, ev(SM,1,st,1,0,0,0,3'd3,0,0,0,0));
      if (st) begin
         exp_ret++;
      end else begin
         step({nm, " wb"}, 1'b0, f, 1'b0, 1'b0, 1'b0, ev(SW,0,0,0,0,0,0,3'd3,0,1,1,0));
         exp_ret++;
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; func = 4'h0; zero_fl = 1'b0; lt_fl = 1'b0; mem_ack = 1'b0;
      step("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));
      step("reset", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));
      run = 1'b0;
      rst_n = 1'b1;
      step("idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));
      step("idle run", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));

      alu_instr("add", 0, 4'b0011, 3'b011, 1'b0);
      alu_instr("sub", 0, 4'b1011, 3'b011, 1'b1);
      alu_instr("nand", 0, 4'b0000, 3'b000, 1'b0);
      alu_instr("nor", 0, 4'b1000, 3'b000, 1'b1);
      alu_instr("srl", 0, 4'b0100, 3'b100, 1'b0);
      alu_instr("sll", 0, 4'b1100, 3'b100, 1'b1);
      alu_instr("mov", 0, 4'b1111, 3'b111, 1'b0);

      branch("beq taken", 4'b0101, 1'b1, 1'b0, 1'b1, 3'b011, 1'b1);
      branch("beq not", 4'b1101, 1'b0, 1'b1, 1'b0, 3'b011, 1'b1);
      branch("blt taken", 4'b0001, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1);
      branch("blt not", 4'b1001, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1);
      branch("jmp", 4'b0111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);

      mem_instr("lb", 4'b0010, 3, 1'b0);
      mem_instr("sb", 4'b0110, 0, 1'b1);
      mem_instr("sb wait", 4'b1110, 2, 1'b1);

      // ack arrives on the 16th FETCH cycle: no fault
      alu_instr("add late ack", 15, 4'b0011, 3'b011, 1'b0);

      fetch("lb reset", 0, 4'b1010);
      step("lb reset exec", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, ev(SE,0,0,0,0,0,0,3'd3,0,0,0,0));
      step("lb reset mem", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, ev(SM,1,0,1,0,0,0,3'd3,0,0,0,0));
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset mem_req", {15'd0, mem_req}, 16'd0);
      chk("async reset state", {13'd0, state_dbg}, 16'd0);
`ifdef OCTA16_SEQ_PERF_EN
      chk("async reset retired", retired, 16'd0);
`endif
      exp_ret = 16'd0;
      #1;
      rst_n = 1'b1;
      step("post reset idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));
      step("post reset run", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, ev(SI,0,0,0,0,0,0,3'd0,0,0,0,0));
      alu_instr("add1", 0, 4'b0011, 3'b011, 1'b0);
      alu_instr("add2", 0, 4'b0011, 3'b011, 1'b0);
      alu_instr("add3", 0, 4'b0011, 3'b011, 1'b0);

      for (int i = 0; i < 16; i++)
         step("timeout fetch", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, ev(SF,1,0,0,0,0,0,3'd0,0,0,0,0));
      for (int i = 0; i < 3; i++)
         step("fault", 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, ev(SX,0,0,0,0,0,0,3'd0,0,0,0,1));

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
